// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the sequential multiply/divide unit.
// Holds the datapath width, the iteration count, the funct3 op encodings,
// the FSM state encodings, and small op-classification helpers.
package muldiv_pkg;

  localparam int REGWIDTH   = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // funct3[2] separates the divide/remainder group from the multiplies.
  function automatic logic op_is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic op_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational step of the multiply/divide datapath.
//   Multiply (shift-add on 64-bit magnitudes):
//     i_acc  product accumulator, i_opb multiplicand (shifts left),
//     i_sh   multiplier (shifts right, LSB selects the add).
//   Divide (restoring, 32-bit magnitudes):
//     i_acc[31:0] partial remainder, i_opb[31:0] divisor,
//     i_sh   dividend shifting out MSB-first while quotient bits shift in.
// Ports:
//   i_is_div          select divide step (1) or multiply step (0)
//   i_acc/i_opb/i_sh  current datapath registers
//   o_acc/o_opb/o_sh  values after one step
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic                  i_is_div,
  input  logic [2*REGWIDTH-1:0] i_acc,
  input  logic [2*REGWIDTH-1:0] i_opb,
  input  logic [REGWIDTH-1:0]   i_sh,
  output logic [2*REGWIDTH-1:0] o_acc,
  output logic [2*REGWIDTH-1:0] o_opb,
  output logic [REGWIDTH-1:0]   o_sh
);

  logic [REGWIDTH:0] w_rem_sh;
  logic [REGWIDTH:0] w_trial;

  always_comb begin
    o_acc    = i_acc;
    o_opb    = i_opb;
    o_sh     = i_sh;
    w_rem_sh = '0;
    w_trial  = '0;
    if (i_is_div) begin
      w_rem_sh = {i_acc[REGWIDTH-1:0], i_sh[REGWIDTH-1]};
      // Partial remainder is always below twice the divisor, so bit REGWIDTH
      // of the trial difference is a clean borrow flag.
      w_trial  = w_rem_sh - {1'b0, i_opb[REGWIDTH-1:0]};
      if (!w_trial[REGWIDTH]) begin
        o_acc = {{REGWIDTH{1'b0}}, w_trial[REGWIDTH-1:0]};
        o_sh  = {i_sh[REGWIDTH-2:0], 1'b1};
      end else begin
        o_acc = {{REGWIDTH{1'b0}}, w_rem_sh[REGWIDTH-1:0]};
        o_sh  = {i_sh[REGWIDTH-2:0], 1'b0};
      end
    end else begin
      if (i_sh[0]) begin
        o_acc = i_acc + i_opb;
      end
      o_opb = {i_opb[2*REGWIDTH-2:0], 1'b0};
      o_sh  = {1'b0, i_sh[REGWIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit for the EX stage.
// One iteration per cycle, 32 iterations; divide-by-zero and signed overflow
// bypass the iterations. Operands are reduced to magnitudes on entry and the
// sign is applied in DONE.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, funct3       op request and op select
//   op_a, op_b          rs1 / rs2 operands
//   flush               abort any operation in progress
//   stall               hold earlier pipeline stages
//   busy                FSM not in IDLE
//   result              final value (valid with result_valid, held otherwise)
//   result_valid        single-cycle result strobe
//
// state | meaning
// IDLE  | waiting for start; accepts a new op when start=1 and flush=0
// CALC  | one shift-add / restoring-divide step per cycle, 32 steps
// DONE  | sign fix-up, result strobe for one cycle, back to IDLE
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          funct3,
  input  logic [REGWIDTH-1:0] op_a,
  input  logic [REGWIDTH-1:0] op_b,
  input  logic                flush,
  output logic                stall,
  output logic                busy,
  output logic [REGWIDTH-1:0] result,
  output logic                result_valid
);

  state_e                r_state;
  state_e                w_next;
  logic [CNT_W-1:0]      r_cnt;
  op_e                   r_op;
  logic [2*REGWIDTH-1:0] r_acc;
  logic [2*REGWIDTH-1:0] r_opb;
  logic [REGWIDTH-1:0]   r_sh;
  logic [REGWIDTH-1:0]   r_op_a;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_div0;
  logic                  r_ovf;
  logic [REGWIDTH-1:0]   r_result;

  op_e                   w_op;
  logic                  w_sa;
  logic                  w_sb;
  logic [REGWIDTH-1:0]   w_mag_a;
  logic [REGWIDTH-1:0]   w_mag_b;
  logic                  w_div0;
  logic                  w_ovf;
  logic                  w_accept;
  logic                  w_last_iter;
  logic [2*REGWIDTH-1:0] w_iter_acc;
  logic [2*REGWIDTH-1:0] w_iter_opb;
  logic [REGWIDTH-1:0]   w_iter_sh;
  logic [2*REGWIDTH-1:0] w_prod;
  logic [REGWIDTH-1:0]   w_quo;
  logic [REGWIDTH-1:0]   w_rem;
  logic [REGWIDTH-1:0]   w_fixed;

  // Operand decode at issue
  assign w_op     = op_e'(funct3);
  assign w_sa     = op_signed_a(w_op) & op_a[REGWIDTH-1];
  assign w_sb     = op_signed_b(w_op) & op_b[REGWIDTH-1];
  assign w_mag_a  = w_sa ? (~op_a + 1'b1) : op_a;
  assign w_mag_b  = w_sb ? (~op_b + 1'b1) : op_b;
  assign w_div0   = op_is_div(w_op) && (op_b == '0);
  assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                    (op_a == {1'b1, {(REGWIDTH-1){1'b0}}}) &&
                    (op_b == {REGWIDTH{1'b1}});
  assign w_accept = (r_state == IDLE) && start && !flush;

  assign w_last_iter = (r_cnt == CNT_W'(ITER_COUNT - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and control outputs
  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stall  = 1'b1;
          w_next = (w_div0 || w_ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (w_last_iter) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = !flush;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (flush) begin
      w_next = IDLE;
    end
  end

  muldiv_iter u_iter (
    .i_is_div (op_is_div(r_op)),
    .i_acc    (r_acc),
    .i_opb    (r_opb),
    .i_sh     (r_sh),
    .o_acc    (w_iter_acc),
    .o_opb    (w_iter_opb),
    .o_sh     (w_iter_sh)
  );

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_acc    <= '0;
      r_opb    <= '0;
      r_sh     <= '0;
      r_op_a   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_op    <= w_op;
        r_op_a  <= op_a;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_div0  <= w_div0;
        r_ovf   <= w_ovf;
        r_acc   <= '0;
        if (op_is_div(w_op)) begin
          r_opb <= {{REGWIDTH{1'b0}}, w_mag_b};
          r_sh  <= w_mag_a;
        end else begin
          r_opb <= {{REGWIDTH{1'b0}}, w_mag_a};
          r_sh  <= w_mag_b;
        end
      end else if ((r_state == CALC) && !flush) begin
        r_acc <= w_iter_acc;
        r_opb <= w_iter_opb;
        r_sh  <= w_iter_sh;
        r_cnt <= r_cnt + 1'b1;
      end
      if (result_valid) begin
        r_result <= w_fixed;
      end
    end
  end

  // Sign fix-up and result select in DONE
  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_sh + 1'b1) : r_sh;
  assign w_rem  = r_neg_r ? (~r_acc[REGWIDTH-1:0] + 1'b1) : r_acc[REGWIDTH-1:0];

  always_comb begin
    w_fixed = '0;
    case (r_op)
      OP_MUL:                       w_fixed = w_prod[REGWIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fixed = w_prod[2*REGWIDTH-1:REGWIDTH];
      OP_DIV, OP_DIVU: begin
        if (r_div0)      w_fixed = {REGWIDTH{1'b1}};
        else if (r_ovf)  w_fixed = {1'b1, {(REGWIDTH-1){1'b0}}};
        else             w_fixed = w_quo;
      end
      OP_REM, OP_REMU: begin
        if (r_div0)      w_fixed = r_op_a;
        else if (r_ovf)  w_fixed = '0;
        else             w_fixed = w_rem;
      end
      default:           w_fixed = '0;
    endcase
  end

  assign result = (r_state == DONE) ? w_fixed : r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;

  int checks;
  int failures;

  muldiv_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RV32M reference behaviour computed with wide integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] ua, ub, up;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f3)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf)    return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
  endfunction

  // Issue one op and watch a fixed 45-cycle window.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input bit mid_start);
    int n, rv_cnt, rv_cyc, stall_cnt, exp_lat;
    logic [31:0] got;
    exp_lat   = is_special(f3, a, b) ? 2 : 34;
    n         = 1;
    rv_cnt    = 0;
    rv_cyc    = 0;
    stall_cnt = 0;
    got       = '0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    for (int k = 0; k < 45; k++) begin
      #1;
      if (stall === 1'b1) stall_cnt++;
      if (result_valid === 1'b1) begin
        rv_cnt++;
        rv_cyc = n;
        got    = result;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (mid_start && exp_lat == 34 && n == 10) begin
        start  = 1'b1;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
    end
    #1;
    chk({tag, " latency"}, 64'(rv_cyc), 64'(exp_lat));
    chk({tag, " strobes"}, 64'(rv_cnt), 64'd1);
    chk({tag, " result"}, {32'b0, got}, {32'b0, exp_res});
    chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat - 1));
    chk({tag, " hold"}, {32'b0, result}, {32'b0, exp_res});
    chk({tag, " busy_after"}, {63'b0, busy}, 64'd0);
  endtask

  // Start an op, then flush or reset at CALC cycle 10.
  task automatic abort_op(input string tag, input bit use_rst);
    int rv_cnt;
    rv_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; op_a = $urandom; op_b = $urandom;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (result_valid === 1'b1) rv_cnt++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (use_rst) begin
      rst   = 1'b1;
      start = 1'b1;
      flush = 1'b1;
    end else begin
      flush = 1'b1;
    end
    #1;
    if (result_valid === 1'b1) rv_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    #1;
    chk({tag, " busy"}, {63'b0, busy}, 64'd0);
    chk({tag, " stall"}, {63'b0, stall}, 64'd0);
    if (use_rst) chk({tag, " result_cleared"}, {32'b0, result}, 64'd0);
    for (int k = 0; k < 40; k++) begin
      if (result_valid === 1'b1) rv_cnt++;
      @(posedge clk); #2;
    end
    chk({tag, " no_strobe"}, 64'(rv_cnt), 64'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          sel;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    funct3   = 3'd0;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset result_valid", {63'b0, result_valid}, 64'd0);
    chk("reset result", {32'b0, result}, 64'd0);
    chk("reset stall", {63'b0, stall}, 64'd0);

    run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulh_m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    run_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("div_by0",    3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0);
    run_op("rem_by0",    3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op("mulhsu_neg", 3'd2, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    abort_op("flush_calc10", 1'b0);
    run_op("after_flush", 3'd5, 32'd1000, 32'd9, 32'd111, 1'b0);
    abort_op("rst_calc10", 1'b1);
    run_op("after_rst", 3'd7, 32'd1000, 32'd9, 32'd1, 1'b1);

    // Same-cycle start and flush must not begin an op.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
    #1;
    chk("start_flush stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    chk("start_flush busy", {63'b0, busy}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'($urandom_range(0, 255)) | 32'h80000000;
      run_op($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, ref_result(rf3, ra, rb), (i % 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
